// File: rtl/ysyx_24100006_axil_sram_slave.sv
// AXI-Lite SRAM responder: one transaction at a time, shared read/write FSM,
// fixed or LFSR-driven accept-to-response latency.
module ysyx_24100006_axil_sram_slave #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE      = 32'h8000_0000,
    parameter int unsigned        DEPTH     = 1024,
    parameter int unsigned        RAND_LAT  = 0,
    parameter int unsigned        LAT_FIXED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     axi_araddr,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_W-1:0]     axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic [ADDR_W-1:0]     axi_awaddr,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_W-1:0]     axi_wdata,
    input  logic [DATA_W/8-1:0]   axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned BYTE_SH = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = 5;
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(DEPTH * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_RESP,
        W_WAIT,
        B_RESP
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           lfsr;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic [ADDR_W-1:0]    offset;
    logic                 hit;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     lat_load;
    logic                 wait_done;
    logic                 lfsr_fb;

    // Decode of the latched transaction address; low byte-offset bits are ignored
    assign offset    = addr_q - BASE;
    assign hit       = (addr_q >= BASE) && ({1'b0, addr_q} < LIMIT);
    assign idx       = IDX_W'(offset >> BYTE_SH);

    // A counter of 0 (LAT_FIXED misconfigured) behaves like 1 so the FSM cannot stall
    assign wait_done = (cnt <= CNT_W'(1));
    assign lat_load  = (RAND_LAT != 0) ? (CNT_W'(lfsr[3:0]) + CNT_W'(1)) : CNT_W'(LAT_FIXED);

    // Handshake readies: reads win over writes, AW and W only taken together
    assign axi_arready = !reset && (state == IDLE);
    assign axi_awready = !reset && (state == IDLE) && !axi_arvalid;
    assign axi_wready  = !reset && (state == IDLE) && !axi_arvalid;

    // Latency LFSR, x^8+x^6+x^5+x^4+1, free-running outside reset
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 8'h5A;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Storage array: byte-lane write on the W_WAIT -> B_RESP edge, never reset
    always_ff @(posedge clk) begin
        if ((state == W_WAIT) && wait_done && hit) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered response channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt        <= '0;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_OKAY;
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_arvalid) begin
                        addr_q <= axi_araddr;
                        cnt    <= lat_load;
                        state  <= R_WAIT;
                    end else if (axi_awvalid && axi_wvalid) begin
                        addr_q  <= axi_awaddr;
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                        cnt     <= lat_load;
                        state   <= W_WAIT;
                    end
                end
                R_WAIT: begin
                    if (wait_done) begin
                        state      <= R_RESP;
                        axi_rvalid <= 1'b1;
                        if (hit) begin
                            axi_rdata <= mem[idx];
                            axi_rresp <= RESP_OKAY;
                        end else begin
                            axi_rdata <= '0;
                            axi_rresp <= RESP_DECERR;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        axi_rvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                W_WAIT: begin
                    if (wait_done) begin
                        state      <= B_RESP;
                        axi_bvalid <= 1'b1;
                        axi_bresp  <= hit ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                B_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_axil_sram_slave.sv
// Directed and randomized checks of the AXI-Lite SRAM responder.
// u_fix runs with a fixed latency of 2, u_rnd with LFSR latency; sel picks which one is driven.
module tb_ysyx_24100006_axil_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;

    logic        arready0, rvalid0, awready0, wready0, bvalid0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0, bresp0;
    logic        arready1, rvalid1, awready1, wready1, bvalid1;
    logic [31:0] rdata1;
    logic [1:0]  rresp1, bresp1;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_24100006_axil_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .BASE(32'h8000_0000), .DEPTH(1024),
        .RAND_LAT(0), .LAT_FIXED(2)
    ) u_fix (
        .clk(clk), .reset(reset),
        .axi_araddr(araddr), .axi_arvalid(arvalid & ~sel), .axi_arready(arready0),
        .axi_rdata(rdata0), .axi_rresp(rresp0), .axi_rvalid(rvalid0), .axi_rready(rready & ~sel),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid & ~sel), .axi_awready(awready0),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid & ~sel), .axi_wready(wready0),
        .axi_bresp(bresp0), .axi_bvalid(bvalid0), .axi_bready(bready & ~sel)
    );

    ysyx_24100006_axil_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .BASE(32'h8000_0000), .DEPTH(1024),
        .RAND_LAT(1), .LAT_FIXED(1)
    ) u_rnd (
        .clk(clk), .reset(reset),
        .axi_araddr(araddr), .axi_arvalid(arvalid & sel), .axi_arready(arready1),
        .axi_rdata(rdata1), .axi_rresp(rresp1), .axi_rvalid(rvalid1), .axi_rready(rready & sel),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid & sel), .axi_awready(awready1),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid & sel), .axi_wready(wready1),
        .axi_bresp(bresp1), .axi_bvalid(bvalid1), .axi_bready(bready & sel)
    );

    assign arready = sel ? arready1 : arready0;
    assign rvalid  = sel ? rvalid1  : rvalid0;
    assign rdata   = sel ? rdata1   : rdata0;
    assign rresp   = sel ? rresp1   : rresp0;
    assign awready = sel ? awready1 : awready0;
    assign wready  = sel ? wready1  : wready0;
    assign bvalid  = sel ? bvalid1  : bvalid0;
    assign bresp   = sel ? bresp1   : bresp0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic chk_lat(input string tag, input int lat, input int exp_lat);
        if (exp_lat != 0) chk(tag, 32'(lat), 32'(exp_lat));
        else              chk(tag, 32'((lat >= 1) && (lat <= 16)), 32'd1);
    endtask

    // All response and ready outputs must be idle while reset is high
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
        chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
        chk({tag, "_arready"}, 32'(arready), 32'd0);
        chk({tag, "_awready"}, 32'(awready), 32'd0);
        chk({tag, "_wready"},  32'(wready),  32'd0);
    endtask

    // Full write transaction; exp_lat==0 means any latency in 1..16 is legal
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input int exp_lat, input int bdelay);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (awready !== 1'b1 || wready !== 1'b1) begin
            @(posedge clk); #2; n++;
            if (n > 64) begin timeout({tag, "_aw"}); awvalid = 1'b0; wvalid = 1'b0; return; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1) begin
            @(posedge clk); #1; n++;
            if (n > 64) begin timeout({tag, "_b"}); return; end
        end
        chk_lat({tag, "_lat"}, n, exp_lat);
        chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            chk({tag, "_bhold_valid"}, 32'(bvalid), 32'd1);
            chk({tag, "_bhold_resp"},  32'(bresp),  32'(exp_resp));
            chk({tag, "_bhold_awrdy"}, 32'(awready), 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk({tag, "_bdrop"}, 32'(bvalid), 32'd0);
    endtask

    // Full read transaction with rready withheld for hold cycles after rvalid
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int exp_lat, input int hold);
        int n;
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (arready !== 1'b1) begin
            @(posedge clk); #2; n++;
            if (n > 64) begin timeout({tag, "_ar"}); arvalid = 1'b0; return; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1) begin
            @(posedge clk); #1; n++;
            if (n > 64) begin timeout({tag, "_r"}); return; end
        end
        chk_lat({tag, "_lat"}, n, exp_lat);
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_rhold_valid"}, 32'(rvalid), 32'd1);
            chk({tag, "_rhold_data"},  rdata, exp_data);
            chk({tag, "_rhold_arrdy"}, 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk({tag, "_rdrop"}, 32'(rvalid), 32'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    logic [31:0] model [8];

    initial begin
        int n;
        int k;
        bit oor;
        bit is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        sel = 1'b0; reset = 1'b1;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

        // Reset state, including readies held low while requests are pending
        repeat (3) @(posedge clk);
        #1;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk_reset_outputs("rst");
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;

        // Write then read, then a partial-strobe overwrite
        do_write("wr1", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 2, 0);
        do_read ("rd1", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 2, 0);
        do_write("wr_strb", 32'h8000_0010, 32'h1122_3344, 4'b0101, 2'b00, 2, 1);
        do_read ("rd_strb", 32'h8000_0010, 32'hDE22_BE44, 2'b00, 2, 0);

        // Read response backpressure
        do_read ("rd_bp", 32'h8000_0010, 32'hDE22_BE44, 2'b00, 2, 5);

        // AR, AW and W together: the read goes first, the write waits on the bus
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0014; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("pri_arready", 32'(arready), 32'd1);
        chk("pri_awready", 32'(awready), 32'd0);
        chk("pri_wready",  32'(wready),  32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n <= 64) begin
            chk("pri_aw_blocked", 32'(awready), 32'd0);
            @(posedge clk); #1; n++;
        end
        if (n > 64) timeout("pri_r");
        chk("pri_rdata", rdata, 32'hDE22_BE44);
        chk("pri_aw_blocked_resp", 32'(awready), 32'd0);
        chk("pri_bvalid_idle", 32'(bvalid), 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        #1;
        chk("pri_aw_ready_after", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n <= 64) begin
            @(posedge clk); #1; n++;
        end
        if (n > 64) timeout("pri_b");
        chk("pri_w_lat", 32'(n), 32'd2);
        chk("pri_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_read("rd_pri_w", 32'h8000_0014, 32'hCAFE_F00D, 2'b00, 2, 0);

        // Address decode boundaries
        do_read ("rd_oor_lo", 32'h7FFF_FFFC, 32'h0, 2'b11, 2, 0);
        do_write("wr_base", 32'h8000_0000, 32'h1234_5678, 4'hF, 2'b00, 2, 0);
        do_write("wr_oor_hi", 32'h8000_1000, 32'hAAAA_AAAA, 4'hF, 2'b11, 2, 0);
        do_read ("rd_base", 32'h8000_0000, 32'h1234_5678, 2'b00, 2, 0);
        do_read ("rd_oor_hi", 32'h8000_1000, 32'h0, 2'b11, 2, 0);
        do_write("wr_top", 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 2'b00, 2, 0);
        do_read ("rd_top_unal", 32'h8000_0FFF, 32'h0BAD_F00D, 2'b00, 2, 0);

        // Lone AW or lone W is never accepted
        awaddr = 32'h8000_0000; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("lone_aw_bvalid", 32'(bvalid), 32'd0);
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("lone_w_bvalid", 32'(bvalid), 32'd0);
        wvalid = 1'b0;
        do_read("rd_lone", 32'h8000_0000, 32'h1234_5678, 2'b00, 2, 0);

        // Reset during W_WAIT aborts the write without touching memory
        awaddr = 32'h8000_0010; wdata = 32'h0000_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("abort_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_arready", 32'(arready), 32'd1);
        do_read("rd_abort", 32'h8000_0010, 32'hDE22_BE44, 2'b00, 2, 0);

        // Random latency instance against a small reference model
        sel = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            model[i] = d;
            do_write("rinit", 32'h8000_0100 + 32'(4 * i), d, 4'hF, 2'b00, 0, 0);
        end
        for (int t = 0; t < 200; t++) begin
            k     = int'($urandom_range(0, 7));
            oor   = ($urandom_range(0, 9) == 0);
            is_wr = ($urandom_range(0, 1) == 1);
            d     = $urandom;
            s     = 4'($urandom_range(0, 15));
            if (oor) begin
                a = ($urandom_range(0, 1) == 1) ? (32'h8000_1000 + 32'(4 * k))
                                                : (32'h7FFF_FF00 + 32'(4 * k));
            end else begin
                a = 32'h8000_0100 + 32'(4 * k) + 32'($urandom_range(0, 3));
            end
            if (is_wr) begin
                do_write("rwr", a, d, s, oor ? 2'b11 : 2'b00, 0, int'($urandom_range(0, 3)));
                if (!oor) model[k] = merge(model[k], d, s);
            end else begin
                do_read("rrd", a, oor ? 32'h0 : model[k], oor ? 2'b11 : 2'b00, 0,
                        int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_axil_sram_slave.md
Name: ysyx_24100006_axil_sram_slave

Overview:
AXI-Lite responder: a single-port word-addressed SRAM model with programmable response latency. It sits on the target side of the IFU/MEMU AXI-Lite initiators and serves one transaction at a time. Read and write share one FSM, so the block exercises the initiators' valid/ready handling under fixed and pseudo-random delays.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)
BASE, 32'h8000_0000, first byte address served
DEPTH, 1024, number of DATA_W words
RAND_LAT, 0, 0 = fixed latency; 1 = LFSR-driven latency
LAT_FIXED, 1, cycles from accept to response valid when RAND_LAT=0 (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
axi_araddr  in  ADDR_W  read address
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rdata  out  DATA_W  read data
axi_rresp  out  2  read response (00 OKAY, 11 DECERR)
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_awaddr  in  ADDR_W  write address
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte enables
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bresp  out  2  write response
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While reset is high: state=IDLE; rvalid=bvalid=0; rdata=0; rresp=bresp=00; all ready outputs=0. LFSR (8-bit, x^8+x^6+x^5+x^4+1) resets to 8'h5A. The SRAM array is not reset.
- States: IDLE, R_WAIT, R_RESP, W_WAIT, B_RESP.
- Ready outputs (combinational, forced to 0 during reset):
  - arready = (state==IDLE).
  - awready = wready = (state==IDLE) && !arvalid.
  - Reads have priority. AW and W are accepted in the same cycle, and only when both are valid. A lone awvalid or wvalid is never accepted.
- IDLE:
  - arvalid → latch araddr, load the delay counter, go to R_WAIT.
  - Otherwise awvalid&&wvalid → latch awaddr/wdata/wstrb, load the counter, go to W_WAIT.
- Delay: counter loads LAT_FIXED (RAND_LAT=0) or {lfsr[3:0]}+1 (RAND_LAT=1, range 1..16). The LFSR advances every cycle outside reset. The counter decrements each cycle; at 1 the FSM moves to the response state on the next edge. Minimum accept-to-valid = 1 cycle.
- Address decode: in range iff BASE <= addr < BASE+DEPTH*DATA_W/8. Index = (addr-BASE)>>2. addr[1:0] is ignored (word aligned).
- R_WAIT→R_RESP: rvalid=1.
  - In range: rdata=mem[idx], rresp=00.
  - Out of range: rdata=0, rresp=11.
  - rdata/rresp are held stable until rready. On rvalid&&rready, rvalid drops and state returns to IDLE (a new AR can be accepted the cycle after).
- W_WAIT→B_RESP:
  - Memory is written on the transition edge. Each byte lane is written only where wstrb[i]=1. Out-of-range addresses are not written and return bresp=11; in-range writes return 00.
  - bvalid=1 until bready. Then IDLE.
- Read-after-write to the same address returns the new data.
- Simultaneous events:
  - arvalid together with aw/wvalid in IDLE: read is served first; the write stays pending on the bus.
  - rready/bready asserted before valid: no effect.
- Reset mid-transaction aborts it. A write that has not reached B_RESP leaves memory unmodified.

Test Plan:
- Reset: assert reset at any time → within the same cycle rvalid=bvalid=arready=awready=0. After release, arready=1.
- Write-then-read: LAT_FIXED=2; write 0x80000010 data 0xDEADBEEF wstrb 4'hF. Expect bvalid 2 cycles after accept with bresp=00. Read 0x80000010 → rvalid 2 cycles after accept, rdata=0xDEADBEEF, rresp=00.
- Byte strobe: after the above, write 0x11223344 with wstrb 4'b0101 to the same address. Read returns 0xDE22BE44.
- Backpressure: hold rready=0 for 5 cycles. rvalid and rdata stay stable, and arready stays 0 until the handshake.
- Priority and decode:
  - arvalid, awvalid and wvalid all asserted in IDLE → AR accepted first; AW/W are accepted only after the R handshake.
  - Read 0x7FFFFFFC → rresp=11, rdata=0.
  - Write 0x80001000 → bresp=11 and memory unchanged.
- Random latency: RAND_LAT=1; 200 mixed transactions checked against a reference model. Every latency must fall in 1..16 and data must match.
